multi_edge_counter: RTL
=======================

Name: multi_edge_counter

Overview:
Parametrised, multi-channel successor to the single-channel gated pulse counter. Counts edges on NUM_CH asynchronous pulse inputs during a shared enable window, with a selectable edge mode. Each window's final counts are latched into a snapshot register and flagged with a one-cycle valid strobe. Used by measurement/frequency-estimation logic that reads per-window counts over a status interface.

Parameters:
NUM_CH, 4, number of independent pulse channels (1..16)
CNT_W, 16, counter width per channel (4..32)
SYNC_STAGES, 2, synchroniser flops per pulse input (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
pulse  in  NUM_CH  asynchronous pulse inputs, bit i = channel i
en_count  in  1  count window gate, synchronous to clk
edge_mode  in  2  00 rising, 01 falling, 10 both, 11 none (counting frozen)
clr  in  1  synchronous clear of counts and overflow flags
count  out  NUM_CH*CNT_W  live counts, channel i at [i*CNT_W +: CNT_W]
overflow  out  NUM_CH  sticky per-channel overflow flags
snap_count  out  NUM_CH*CNT_W  counts latched at end of window
snap_valid  out  1  one-cycle strobe when snap_count updates

Behaviour:
- Reset (rst=0 at clk edge): count, overflow, snap_count, snap_valid, synchroniser flops, edge history and en_d all 0.
- Per channel: SYNC_STAGES-flop synchroniser, then one history flop; edge_hit from the last two stages per edge_mode.
- Latency: pulse transition to count increment = SYNC_STAGES+1 clk cycles (3 at default).
- en_d: registered copy of en_count. win_start = en_count & ~en_d. win_end = ~en_count & en_d.
- Per-channel next count, in priority order:
  1. clr=1 -> 0; overflow <= 0.
  2. win_start -> (edge_hit ? 1 : 0); overflow <= 0.
  3. en_count=1 & edge_hit -> increment.
  4. Otherwise hold.
- Increment at all-ones: wraps to 0; overflow set (sticky).
- win_end: snap_count <= count (registered value; no increment in that cycle since en_count=0). snap_valid=1 for exactly that cycle. Live count holds until the next clr or win_start.
- clr and win_end in the same cycle: snapshot takes the pre-clear count; count clears.
- edge_mode change takes effect on the next edge_hit evaluation; synchroniser and history are not flushed. 11 freezes counts but still allows snapshots.
- Reset mid-window: everything clears, no snap_valid. A window open at reset release (en_count=1, en_d=0) is treated as a new window start.
- Pulse high at reset release: registers as a rising edge SYNC_STAGES+1 cycles later. This is documented behaviour.
- Pulse widths below 2 clk periods are not guaranteed to be counted.

Optional Feature:
- Macro: MULTI_EDGE_COUNTER_SATURATE_EN
- Defined: increment at all-ones holds at all-ones and sets overflow.
- Undefined: wrap-around as above. All other behaviour is identical.

Decomposition:
- Package multi_edge_counter_pkg holds the edge_mode encodings: EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_NONE=2'b11.
- Sub-module edge_count_ch holds per-channel logic: synchroniser, history flop, edge_hit decode, counter, overflow. Instantiated NUM_CH times via generate.
- Top level holds en_d, window decode, snapshot register and snap_valid.

Test Plan:
- clk 10 ns, all pulses period 40 ns, rising mode, en_count high for 1000 cycles -> snap_count = 250 on every channel, one snap_valid pulse, overflow = 0.
- Same stimulus with edge_mode=10 -> snap_count = 500 per channel. With edge_mode=11 -> 0.
- Channels at periods 40/80/160/20 ns, 1000-cycle window -> snap_count = 250/125/62/500 (±1 for phase alignment).
- CNT_W=4, 20 rising edges in a window -> count = 4, overflow = 1. With SATURATE_EN defined -> count = 15, overflow = 1.
- Two back-to-back windows separated by 1 idle cycle -> second window restarts from 0 (or 1 if an edge coincides with win_start). clr asserted mid-window -> count = 0 next cycle and overflow cleared.
- rst=0 for 1 cycle mid-window -> all outputs 0 next cycle, no snap_valid. Counting resumes from 0 with en_count still high.

Source files
------------

// File: rtl/multi_edge_counter_pkg.sv
// Shared definitions for the multi-channel gated edge counter.
package multi_edge_counter_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_e;

    // Edge decode between the newest synchronised sample and its history copy.
    function automatic logic edge_detect(edge_mode_e mode, logic cur, logic prev);
        logic hit;
        unique case (mode)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            EDGE_BOTH: hit = cur ^ prev;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_edge_counter_ch.sv
// Per-channel logic: input synchroniser, history flop, edge decode, counter
// and sticky overflow. Optional macro MULTI_EDGE_COUNTER_SATURATE_EN makes the
// counter hold at all-ones instead of wrapping.
module edge_count_ch
    import multi_edge_counter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic [1:0]       edge_mode,
    input  logic             en_count,
    input  logic             win_start,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   edge_hit;

    // Synchroniser shift, history capture and edge decode.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pulse_in};
        hist_d   = sync_q[SYNC_STAGES-1];
        edge_hit = edge_detect(edge_mode_e'(edge_mode), sync_q[SYNC_STAGES-1], hist_q);
    end

    // Counter next state: clear, then window start, then gated increment.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (win_start) begin
            count_d = edge_hit ? CNT_W'(1) : '0;
            ovf_d   = 1'b0;
        end else if (en_count && edge_hit) begin
            if (&count_q) begin
                ovf_d = 1'b1;
`ifdef MULTI_EDGE_COUNTER_SATURATE_EN
                count_d = count_q;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel gated edge counter top: window decode, per-channel counters
// and end-of-window snapshot. Optional macro MULTI_EDGE_COUNTER_SATURATE_EN
// (handled in edge_count_ch) selects saturating counters.
module multi_edge_counter
    import multi_edge_counter_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       pulse,
    input  logic                    en_count,
    input  logic [1:0]              edge_mode,
    input  logic                    clr,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH*CNT_W-1:0] snap_count,
    output logic                    snap_valid
);

    logic                    en_d_q, en_d_d;
    logic [NUM_CH*CNT_W-1:0] snap_count_q, snap_count_d;
    logic                    snap_valid_q, snap_valid_d;
    logic                    win_start, win_end;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            edge_count_ch #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .pulse_in  (pulse[g]),
                .edge_mode (edge_mode),
                .en_count  (en_count),
                .win_start (win_start),
                .clr       (clr),
                .count     (count[g*CNT_W +: CNT_W]),
                .overflow  (overflow[g])
            );
        end
    endgenerate

    // Window edges and snapshot of the registered (pre-clear) counts.
    always_comb begin
        win_start    = en_count & ~en_d_q;
        win_end      = ~en_count & en_d_q;
        en_d_d       = en_count;
        snap_count_d = win_end ? count : snap_count_q;
        snap_valid_d = win_end;
    end

    // Window and snapshot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_d_q       <= 1'b0;
            snap_count_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            en_d_q       <= en_d_d;
            snap_count_q <= snap_count_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_count = snap_count_q;
    assign snap_valid = snap_valid_q;

endmodule
